mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch and data requesters of the request unit/datapath.
- Non-pipelined grant/access/respond sequencer.
- Data has priority, with a starvation guard that lets fetch through.
- Timeout watchdog flags a hung RAM.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data requesters; data has priority with a fetch starvation guard.
// Optional build macro ARB_STATS_EN adds hit counters and a fetch starvation counter.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
`ifdef ARB_STATS_EN
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [15:0]       starve_cnt,
`endif
    output logic              timeout_err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t            r_state;
    logic              r_own_d;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store;
    logic [SW-1:0]     r_dstreak;
    logic [CW-1:0]     r_wait;
    logic              r_ramREN;
    logic              r_ramWEN;
    logic              r_ihit;
    logic              r_dhit;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              r_terr;

    logic w_dreq;
    logic w_igrant;
    logic w_dgrant;
    logic w_dwrite;

    // Fetch wins only when data has already taken MAX_DSTREAK grants in a row against it.
    assign w_dreq   = dREN | dWEN;
    assign w_igrant = iREN & (~w_dreq | (r_dstreak == STREAK_MAX));
    assign w_dgrant = w_dreq & ~w_igrant;
    assign w_dwrite = w_dgrant & dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_own_d   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
            r_dstreak <= '0;
            r_wait    <= '0;
            r_ramREN  <= 1'b0;
            r_ramWEN  <= 1'b0;
            r_ihit    <= 1'b0;
            r_dhit    <= 1'b0;
            r_iload   <= '0;
            r_dload   <= '0;
            r_terr    <= 1'b0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_igrant || w_dgrant) begin
                        r_own_d  <= w_dgrant;
                        r_wr     <= w_dwrite;
                        r_addr   <= w_dgrant ? daddr : iaddr;
                        r_store  <= w_dwrite ? dstore : '0;
                        r_ramREN <= ~w_dwrite;
                        r_ramWEN <= w_dwrite;
                        r_wait   <= '0;
                        r_state  <= ACC;
                        if (w_dgrant && iREN)
                            r_dstreak <= (r_dstreak == STREAK_MAX) ? r_dstreak : r_dstreak + SW'(1);
                        else
                            r_dstreak <= '0;
                    end
                end
                ACC: begin
                    if (ramready || r_wait == WAIT_LAST) begin
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                        r_ihit   <= ~r_own_d;
                        r_dhit   <= r_own_d;
                        r_state  <= RESP;
                        if (!ramready) begin
                            r_terr <= 1'b1;
                            if (r_own_d) r_dload <= '0;
                            else         r_iload <= '0;
                        end else if (!r_wr) begin
                            if (r_own_d) r_dload <= ramload;
                            else         r_iload <= ramload;
                        end
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ramREN      = r_ramREN;
    assign ramWEN      = r_ramWEN;
    assign ramaddr     = r_addr;
    assign ramstore    = r_store;
    assign ihit        = r_ihit;
    assign dhit        = r_dhit;
    assign iload       = r_iload;
    assign dload       = r_dload;
    assign timeout_err = r_terr;

`ifdef ARB_STATS_EN
    logic [31:0] r_icount;
    logic [31:0] r_dcount;
    logic [15:0] r_starve;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount <= '0;
            r_dcount <= '0;
            r_starve <= '0;
        end else begin
            if (r_ihit) r_icount <= r_icount + 32'd1;
            if (r_dhit) r_dcount <= r_dcount + 32'd1;
            if (iREN && !(r_state == IDLE && w_igrant) && r_starve != 16'hFFFF)
                r_starve <= r_starve + 16'd1;
        end
    end

    assign icount     = r_icount;
    assign dcount     = r_dcount;
    assign starve_cnt = r_starve;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected RAM accesses and hits are queued at issue, checked by RAM model and hit monitor.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, timeout_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STATS_EN
    logic [31:0] icount, dcount;
    logic [15:0] starve_cnt;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready),
`ifdef ARB_STATS_EN
        .icount(icount), .dcount(dcount), .starve_cnt(starve_cnt),
`endif
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic is_i; logic [31:0] data; } hit_t;
    typedef struct packed { logic ren; logic wen; logic [31:0] addr; logic [31:0] store; } acc_t;

    hit_t exp_hits[$];
    acc_t exp_accs[$];
    int   errors = 0;
    int   checks = 0;

    int          ram_delay = 1;
    logic [31:0] ram_data  = 32'h0;
    int          acc_cyc   = 0;
    int          last_len  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_acc(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] s);
        acc_t e;
        e.ren = ren; e.wen = wen; e.addr = a; e.store = s;
        exp_accs.push_back(e);
    endfunction

    function automatic void push_hit(input logic is_i, input logic [31:0] d);
        hit_t e;
        e.is_i = is_i; e.data = d;
        exp_hits.push_back(e);
    endfunction

    // RAM model: checks each access on its first cycle and answers after ram_delay cycles (0 = never).
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (acc_cyc == 0) begin
                acc_t got, e;
                got.ren = ramREN; got.wen = ramWEN; got.addr = ramaddr; got.store = ramstore;
                checks++;
                if (exp_accs.size() == 0) begin
                    errors++;
                    $display("FAIL ram_access: unexpected access %h", got);
                end else begin
                    e = exp_accs.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL ram_access: got %h expected %h", got, e);
                    end
                end
            end
            acc_cyc++;
            ramready = (ram_delay != 0) && (acc_cyc == ram_delay);
            ramload  = ram_data;
        end else begin
            if (acc_cyc != 0) last_len = acc_cyc;
            acc_cyc  = 0;
            ramready = 1'b0;
        end
    end

    // Hit monitor.
    always @(negedge CLK) begin
        if (nRST && (ihit || dhit)) begin
            hit_t e;
            checks++;
            if (ihit && dhit) begin
                errors++;
                $display("FAIL hit_excl: ihit=%b dhit=%b required not both", ihit, dhit);
            end else if (exp_hits.size() == 0) begin
                errors++;
                $display("FAIL hit_unexpected: ihit=%b dhit=%b iload=%h dload=%h", ihit, dhit, iload, dload);
            end else begin
                e = exp_hits.pop_front();
                if (e.is_i !== ihit || e.data !== (ihit ? iload : dload)) begin
                    errors++;
                    $display("FAIL hit: got is_i=%b data=%h expected is_i=%b data=%h",
                             ihit, ihit ? iload : dload, e.is_i, e.data);
                end
            end
        end
    end

    task automatic serve(input int n_hits, input bit hold_d, output int first_lat);
        int hits = 0;
        int cyc  = 0;
        first_lat = -1;
        while (hits < n_hits && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (ihit) begin
                hits++;
                iREN = 1'b0;
                if (first_lat < 0) first_lat = cyc;
            end
            if (dhit) begin
                hits++;
                if (!hold_d || hits >= n_hits) begin dREN = 1'b0; dWEN = 1'b0; end
                if (first_lat < 0) first_lat = cyc;
            end
        end
        if (hits < n_hits) begin
            checks++;
            errors++;
            $display("FAIL serve_budget: hits %0d required %0d", hits, n_hits);
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramready = 0; ramload = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Instruction read, RAM ready on the second ACC cycle.
        ram_delay = 2; ram_data = 32'h2402000A;
        push_acc(1'b1, 1'b0, 32'h40, 32'h0);
        push_hit(1'b1, 32'h2402000A);
        iaddr = 32'h40; iREN = 1'b1;
        serve(1, 1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_acc_len", 32'(last_len), 32'd2);

        // Simultaneous data write and fetch: data first.
        ram_delay = 1; ram_data = 32'h11112222;
        push_acc(1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
        push_acc(1'b1, 1'b0, 32'h44, 32'h0);
        push_hit(1'b0, 32'h0);
        push_hit(1'b1, 32'h11112222);
        daddr = 32'h80; dstore = 32'hDEADBEEF; dWEN = 1'b1;
        iaddr = 32'h44; iREN = 1'b1;
        serve(2, 1'b0, lat);

        // Starvation guard: four data grants, then fetch, then data again.
        ram_delay = 1; ram_data = 32'hA5A50001;
        for (int k = 0; k < 4; k++) push_acc(1'b1, 1'b0, 32'h100, 32'h0);
        push_acc(1'b1, 1'b0, 32'h48, 32'h0);
        push_acc(1'b1, 1'b0, 32'h100, 32'h0);
        for (int k = 0; k < 4; k++) push_hit(1'b0, 32'hA5A50001);
        push_hit(1'b1, 32'hA5A50001);
        push_hit(1'b0, 32'hA5A50001);
        daddr = 32'h100; dREN = 1'b1;
        iaddr = 32'h48; iREN = 1'b1;
        serve(6, 1'b1, lat);

        // Watchdog: RAM never ready.
        ram_delay = 0; ram_data = 32'h12345678;
        push_acc(1'b1, 1'b0, 32'h200, 32'h0);
        push_hit(1'b0, 32'h0);
        daddr = 32'h200; dREN = 1'b1;
        serve(1, 1'b0, lat);
        chk("t4_acc_len", 32'(last_len), 32'd8);
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        ram_delay = 1; ram_data = 32'h00000777;
        push_acc(1'b1, 1'b0, 32'h4C, 32'h0);
        push_hit(1'b1, 32'h00000777);
        iaddr = 32'h4C; iREN = 1'b1;
        serve(1, 1'b0, lat);
        chk("t4_timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset during ACC.
        ram_delay = 5;
        iaddr = 32'h50; iREN = 1'b1;
        @(posedge CLK); #1;
        chk("t5_ramREN_acc", 32'(ramREN), 32'd1);
        chk("t5_ramaddr_acc", ramaddr, 32'h50);
        nRST = 1'b0;
        #1;
        chk("t5_ramREN_rst", 32'(ramREN), 32'd0);
        chk("t5_ihit_rst", 32'(ihit), 32'd0);
        iREN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk("t5_timeout_cleared", 32'(timeout_err), 32'd0);
        @(posedge CLK); #1;
        ram_delay = 3; ram_data = 32'h0BADF00D;
        push_acc(1'b1, 1'b0, 32'h50, 32'h0);
        push_hit(1'b1, 32'h0BADF00D);
        iREN = 1'b1;
        serve(1, 1'b0, lat);
        chk("t5_latency", 32'(lat), 32'd5);

        // Read and write together: treated as write, dload unchanged.
        ram_delay = 1; ram_data = 32'h99999999;
        push_acc(1'b0, 1'b1, 32'h300, 32'hCAFEF00D);
        push_hit(1'b0, 32'h0);
        daddr = 32'h300; dstore = 32'hCAFEF00D; dREN = 1'b1; dWEN = 1'b1;
        serve(1, 1'b0, lat);
        chk("t6_dload_hold", dload, 32'h0);

        chk("end_hits_pending", 32'(exp_hits.size()), 32'd0);
        chk("end_accs_pending", 32'(exp_accs.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
